// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered next-PC generator with exception/jump/branch priority and a return-address check stack
module pc_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              exc,
    input  logic [2:0]        br_cond,
    input  logic [1:0]        jump,
    input  logic              ret,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target,
    input  logic [31:0]       busA,
    input  logic              zero,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              taken,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_miss
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W:0]    count;

    logic [ADDR_W-1:0] link_pc, br_off, br_target, j_target, jr_target, ras_top;
    logic [ADDR_W-1:0] next_pc;
    logic              next_taken, cond_true, do_push, is_ret, update;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign link_pc   = br_pc + ADDR_W'(4);
    assign br_off    = {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
    assign br_target = link_pc + br_off;
    assign j_target  = {br_pc[ADDR_W-1:28], target, 2'b00};
    assign jr_target = {busA[ADDR_W-1:2], 2'b00};
    assign ras_top   = ras[ptr - PTR_W'(1)];
    assign ras_empty = (count == '0);
    assign ras_full  = (count == (PTR_W+1)'(RAS_DEPTH));
    assign update    = !rst && !exc && !stall;

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            3'b001:  cond_true = zero;
            3'b010:  cond_true = !zero;
            3'b011:  cond_true = !busA[31];
            3'b100:  cond_true = !busA[31] && (busA != 32'd0);
            3'b101:  cond_true = busA[31] || (busA == 32'd0);
            3'b110:  cond_true = busA[31];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        next_pc    = pc_plus4;
        next_taken = 1'b0;
        do_push    = 1'b0;
        is_ret     = 1'b0;
        if (jump != 2'b00) begin
            next_taken = 1'b1;
            if (jump == 2'b10) begin
                next_pc = jr_target;
                is_ret  = ret;
            end else begin
                next_pc = j_target;
                do_push = (jump == 2'b11);
            end
        end else if (cond_true) begin
            next_pc    = br_target;
            next_taken = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC[ADDR_W-1:0];
            taken    <= 1'b0;
            ras_miss <= 1'b0;
            ptr      <= '0;
            count    <= '0;
        end else if (exc) begin
            pc       <= EXC_VEC[ADDR_W-1:0];
            taken    <= 1'b1;
            ras_miss <= 1'b0;
        end else if (!stall) begin
            pc       <= next_pc;
            taken    <= next_taken;
            ras_miss <= is_ret && (ras_empty || (ras_top != jr_target));
            if (do_push) begin
                ptr <= ptr + PTR_W'(1);
                if (!ras_full)
                    count <= count + (PTR_W+1)'(1);
            end else if (is_ret && !ras_empty) begin
                ptr   <= ptr - PTR_W'(1);
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // When full, ptr already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (update && do_push)
            ras[ptr] <= link_pc;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector bench for pc_unit
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst, stall, exc, ret, zero;
    logic [2:0]  br_cond;
    logic [1:0]  jump;
    logic [31:0] br_pc, busA;
    logic [15:0] imm16;
    logic [25:0] target;
    logic [31:0] pc, pc_plus4;
    logic        taken, ras_empty, ras_full, ras_miss;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .exc(exc), .br_cond(br_cond),
        .jump(jump), .ret(ret), .br_pc(br_pc), .imm16(imm16), .target(target),
        .busA(busA), .zero(zero), .pc(pc), .pc_plus4(pc_plus4), .taken(taken),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss)
    );

    typedef struct {
        logic        rst, stall, exc;
        logic [2:0]  br_cond;
        logic [1:0]  jump;
        logic        ret;
        logic [31:0] br_pc;
        logic [15:0] imm16;
        logic [25:0] target;
        logic [31:0] busA;
        logic        zero;
        logic [31:0] e_pc;
        logic        e_taken, e_empty, e_full, e_miss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic s, logic x, logic [2:0] c, logic [1:0] j,
                                logic rt, logic [31:0] bp, logic [15:0] im, logic [25:0] tg,
                                logic [31:0] a, logic z, logic [31:0] epc, logic et,
                                logic ee, logic ef, logic em);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = x; v.br_cond = c; v.jump = j; v.ret = rt;
        v.br_pc = bp; v.imm16 = im; v.target = tg; v.busA = a; v.zero = z;
        v.e_pc = epc; v.e_taken = et; v.e_empty = ee; v.e_full = ef; v.e_miss = em;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        @(negedge clk);
        rst = v.rst; stall = v.stall; exc = v.exc; br_cond = v.br_cond; jump = v.jump;
        ret = v.ret; br_pc = v.br_pc; imm16 = v.imm16; target = v.target;
        busA = v.busA; zero = v.zero;
        @(posedge clk);
        #1;
        chk("pc", idx, pc, v.e_pc);
        chk("pc_plus4", idx, pc_plus4, v.e_pc + 32'd4);
        chk("taken", idx, 32'(taken), 32'(v.e_taken));
        chk("ras_empty", idx, 32'(ras_empty), 32'(v.e_empty));
        chk("ras_full", idx, 32'(ras_full), 32'(v.e_full));
        chk("ras_miss", idx, 32'(ras_miss), 32'(v.e_miss));
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; exc = 1'b0; br_cond = 3'b000; jump = 2'b00; ret = 1'b0;
        br_pc = '0; imm16 = '0; target = '0; busA = '0; zero = 1'b0;

        //            rst s  x  cond    jump  ret br_pc         imm16     target      busA          z    | pc       tk em fu mi
        tbl.push_back(mk(1, 0, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h3000, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h3004, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h3008, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h300C, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd1, 2'd0, 0, 32'h3010,    16'hFFFC, 26'h0,      32'h0,        1, 32'h3004, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd1, 2'd0, 0, 32'h3010,    16'hFFFC, 26'h0,      32'h0,        0, 32'h3008, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd4, 2'd0, 0, 32'h3010,    16'h0010, 26'h0,      32'h0,        0, 32'h300C, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd6, 2'd0, 0, 32'h3010,    16'h0010, 26'h0,      32'h8000_0000, 0, 32'h3054, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd3, 2'd0, 0, 32'h3010,    16'h0010, 26'h0,      32'h8000_0000, 0, 32'h3058, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd5, 2'd0, 0, 32'h3100,    16'h0002, 26'h0,      32'h0,        0, 32'h310C, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd2, 2'd0, 0, 32'h3200,    16'h0000, 26'h0,      32'h5,        0, 32'h3204, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd7, 2'd0, 0, 32'h3200,    16'h0040, 26'h0,      32'h0,        1, 32'h3208, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd1, 2'd1, 0, 32'h3300,    16'h0010, 26'h800,    32'h0,        1, 32'h2000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd3, 0, 32'h3020,    16'h0,    26'h1000,   32'h0,        0, 32'h4000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h4000,    16'h0,    26'h0,      32'h3024,     0, 32'h3024, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd2, 0, 32'h3024,    16'h0,    26'h0,      32'h5003,     0, 32'h5000, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h5000,    16'h0,    26'h0,      32'h6000,     0, 32'h6000, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h6000, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h6004, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 3'd0, 2'd0, 0, 32'h0,       16'h0,    26'h0,      32'h0,        0, 32'h4180, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3'd0, 2'd3, 0, 32'h3020,    16'h0,    26'h1000,   32'h0,        0, 32'h4180, 1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 0, 3'd0, 2'd3, 0, 32'h3020,    16'h0,    26'h1000,   32'h0,        0, 32'h3000, 0, 1, 0, 0));
        // Stalled JAL above must not have pushed: a return now sees an empty stack.
        tbl.push_back(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h3000,    16'h0,    26'h0,      32'h3024,     0, 32'h3024, 1, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i);

        // Overflow: five calls into a four-deep stack, then five returns.
        apply(mk(1, 0, 0, 3'd0, 2'd0, 0, 32'h0, 16'h0, 26'h0, 32'h0, 0, 32'h3000, 0, 1, 0, 0), 100);
        for (int k = 1; k <= 5; k++)
            apply(mk(0, 0, 0, 3'd0, 2'd3, 0, 32'(k * 256), 16'h0, 26'(k * 32'h400), 32'h0, 0,
                     32'(k * 32'h1000), 1, 0, (k >= 4), 0), 100 + k);
        for (int i = 0; i < 5; i++)
            apply(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h0, 16'h0, 26'h0, 32'(32'h504 - i * 256), 0,
                     32'(32'h504 - i * 256), 1, (i >= 3), 0, (i == 4)), 110 + i);
        // Wrong return target still redirects, flags a miss and pops.
        apply(mk(0, 0, 0, 3'd0, 2'd3, 0, 32'h700, 16'h0, 26'h0,   32'h0,   0, 32'h0,   1, 0, 0, 0), 120);
        apply(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h0,   16'h0, 26'h0,   32'h708, 0, 32'h708, 1, 1, 0, 1), 121);
        apply(mk(0, 0, 0, 3'd0, 2'd3, 0, 32'h800, 16'h0, 26'h100, 32'h0,   0, 32'h400, 1, 0, 0, 0), 122);
        apply(mk(0, 0, 0, 3'd0, 2'd2, 1, 32'h0,   16'h0, 26'h0,   32'h804, 0, 32'h804, 1, 1, 0, 0), 123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
